// File: rtl/scorer_pkg.sv
// Shared encodings for the match scorer: FSM states and serve side.
package scorer_pkg;

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        ROUND_END  = 2'd1,
        MATCH_OVER = 2'd2
    } state_e;

    localparam logic SERVE_P1 = 1'b0;
    localparam logic SERVE_P2 = 1'b1;

endpackage

// File: rtl/match_scorer_if.sv
// Bundle between the collision logic / display side and the match scorer.
interface match_scorer_if #(
    parameter int SCORE_W = 4,
    parameter int ROUND_W = 4
);
    logic               tick_en;
    logic               p1_point;
    logic               p2_point;
    logic               new_match;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [ROUND_W-1:0] p1_rounds;
    logic [ROUND_W-1:0] p2_rounds;
    logic               round_over;
    logic               match_over;
    logic               p1_winner;
    logic               p2_winner;
    logic               serve;

    modport master (
        output tick_en, p1_point, p2_point, new_match,
        input  p1_score, p2_score, p1_rounds, p2_rounds,
        input  round_over, match_over, p1_winner, p2_winner, serve
    );

    modport slave (
        input  tick_en, p1_point, p2_point, new_match,
        output p1_score, p2_score, p1_rounds, p2_rounds,
        output round_over, match_over, p1_winner, p2_winner, serve
    );
endinterface

// File: rtl/match_scorer_edge.sv
// Tick-qualified rising-edge detector; history only advances on ticks.
module tick_edge_detect (
    input  logic clk,
    input  logic Resetn,
    input  logic tick_en,
    input  logic in,
    output logic rise
);
    logic prev_r;

    // Edge history register, frozen between ticks
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            prev_r <= 1'b0;
        end else if (tick_en) begin
            prev_r <= in;
        end else begin
            prev_r <= prev_r;
        end
    end

    assign rise = tick_en & in & ~prev_r;
endmodule

// File: rtl/match_scorer.sv
// Two-player point/round/match keeper with win-by margin, deuce folding and a timed round-end hold.
module match_scorer
    import scorer_pkg::*;
#(
    parameter int POINTS_TO_WIN = 9,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int WIN_BY        = 1,
    parameter int SCORE_W       = 4,
    parameter int ROUND_W       = 4,
    parameter int HOLD_TICKS    = 100
) (
    input  logic           CLOCK_50,
    input  logic           Resetn,
    match_scorer_if.slave  bus
);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    // two spare bits so scorer+1 and other+WIN_BY cannot overflow
    localparam int CW     = SCORE_W + 2;

    localparam logic [CW-1:0]      WIN_PTS    = CW'(POINTS_TO_WIN);
    localparam logic [CW-1:0]      FOLD_PTS   = CW'(POINTS_TO_WIN - 1);
    localparam logic [CW-1:0]      LEAD       = CW'(WIN_BY);
    localparam logic [SCORE_W-1:0] FOLD_SCORE = SCORE_W'(POINTS_TO_WIN - 1);
    localparam logic [ROUND_W-1:0] ROUND_LIM  = ROUND_W'(ROUNDS_TO_WIN);
    localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(HOLD_TICKS);

    logic p1_rise_s, p2_rise_s, nm_rise_s;

    tick_edge_detect u_p1_edge (.clk(CLOCK_50), .Resetn(Resetn), .tick_en(bus.tick_en), .in(bus.p1_point),  .rise(p1_rise_s));
    tick_edge_detect u_p2_edge (.clk(CLOCK_50), .Resetn(Resetn), .tick_en(bus.tick_en), .in(bus.p2_point),  .rise(p2_rise_s));
    tick_edge_detect u_nm_edge (.clk(CLOCK_50), .Resetn(Resetn), .tick_en(bus.tick_en), .in(bus.new_match), .rise(nm_rise_s));

    state_e             state_r, state_nxt_s;
    logic [SCORE_W-1:0] p1_score_r, p2_score_r, p1_score_nxt_s, p2_score_nxt_s;
    logic [ROUND_W-1:0] p1_rounds_r, p2_rounds_r, p1_rounds_nxt_s, p2_rounds_nxt_s;
    logic [HOLD_W-1:0]  hold_r, hold_nxt_s;
    logic               serve_r, serve_nxt_s;
    logic               p1_win_r, p2_win_r, p1_win_nxt_s, p2_win_nxt_s;
    logic               round_over_r, match_over_r;
    logic [CW-1:0]      scorer_s, other_s, scorer_inc_s;
    logic               round_won_s, fold_s;

    // State and counter registers; every output is taken from here
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_r      <= PLAY;
            p1_score_r   <= {SCORE_W{1'b0}};
            p2_score_r   <= {SCORE_W{1'b0}};
            p1_rounds_r  <= {ROUND_W{1'b0}};
            p2_rounds_r  <= {ROUND_W{1'b0}};
            hold_r       <= {HOLD_W{1'b0}};
            serve_r      <= SERVE_P1;
            p1_win_r     <= 1'b0;
            p2_win_r     <= 1'b0;
            round_over_r <= 1'b0;
            match_over_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            p1_score_r   <= p1_score_nxt_s;
            p2_score_r   <= p2_score_nxt_s;
            p1_rounds_r  <= p1_rounds_nxt_s;
            p2_rounds_r  <= p2_rounds_nxt_s;
            hold_r       <= hold_nxt_s;
            serve_r      <= serve_nxt_s;
            p1_win_r     <= p1_win_nxt_s;
            p2_win_r     <= p2_win_nxt_s;
            round_over_r <= (state_nxt_s == ROUND_END);
            match_over_r <= (state_nxt_s == MATCH_OVER);
        end
    end

    // Next-state logic; rise strobes are already tick-qualified
    always_comb begin
        state_nxt_s     = state_r;
        p1_score_nxt_s  = p1_score_r;
        p2_score_nxt_s  = p2_score_r;
        p1_rounds_nxt_s = p1_rounds_r;
        p2_rounds_nxt_s = p2_rounds_r;
        hold_nxt_s      = hold_r;
        serve_nxt_s     = serve_r;
        p1_win_nxt_s    = p1_win_r;
        p2_win_nxt_s    = p2_win_r;

        scorer_s     = p1_rise_s ? {2'b00, p1_score_r} : {2'b00, p2_score_r};
        other_s      = p1_rise_s ? {2'b00, p2_score_r} : {2'b00, p1_score_r};
        scorer_inc_s = scorer_s + CW'(1);
        round_won_s  = (scorer_inc_s >= WIN_PTS) && (scorer_inc_s >= other_s + LEAD);
        fold_s       = (scorer_inc_s == other_s) && (scorer_inc_s >= FOLD_PTS);

        if (nm_rise_s) begin
            state_nxt_s     = PLAY;
            p1_score_nxt_s  = {SCORE_W{1'b0}};
            p2_score_nxt_s  = {SCORE_W{1'b0}};
            p1_rounds_nxt_s = {ROUND_W{1'b0}};
            p2_rounds_nxt_s = {ROUND_W{1'b0}};
            hold_nxt_s      = {HOLD_W{1'b0}};
            serve_nxt_s     = SERVE_P1;
            p1_win_nxt_s    = 1'b0;
            p2_win_nxt_s    = 1'b0;
        end else begin
            case (state_r)
                PLAY: begin
                    if (p1_rise_s ^ p2_rise_s) begin
                        if (round_won_s) begin
                            state_nxt_s = ROUND_END;
                            hold_nxt_s  = HOLD_INIT;
                            if (p1_rise_s) begin
                                p1_score_nxt_s  = scorer_inc_s[SCORE_W-1:0];
                                p1_rounds_nxt_s = p1_rounds_r + ROUND_W'(1);
                                serve_nxt_s     = SERVE_P2;
                            end else begin
                                p2_score_nxt_s  = scorer_inc_s[SCORE_W-1:0];
                                p2_rounds_nxt_s = p2_rounds_r + ROUND_W'(1);
                                serve_nxt_s     = SERVE_P1;
                            end
                        end else if (fold_s) begin
                            p1_score_nxt_s = FOLD_SCORE;
                            p2_score_nxt_s = FOLD_SCORE;
                        end else if (p1_rise_s) begin
                            p1_score_nxt_s = scorer_inc_s[SCORE_W-1:0];
                        end else begin
                            p2_score_nxt_s = scorer_inc_s[SCORE_W-1:0];
                        end
                    end else begin
                        state_nxt_s = PLAY;
                    end
                end
                ROUND_END: begin
                    if (bus.tick_en) begin
                        // serve points at the loser, so it also identifies the round winner
                        if (hold_r <= HOLD_W'(1)) begin
                            hold_nxt_s     = {HOLD_W{1'b0}};
                            p1_score_nxt_s = {SCORE_W{1'b0}};
                            p2_score_nxt_s = {SCORE_W{1'b0}};
                            if ((serve_r == SERVE_P2) && (p1_rounds_r == ROUND_LIM)) begin
                                state_nxt_s  = MATCH_OVER;
                                p1_win_nxt_s = 1'b1;
                            end else if ((serve_r == SERVE_P1) && (p2_rounds_r == ROUND_LIM)) begin
                                state_nxt_s  = MATCH_OVER;
                                p2_win_nxt_s = 1'b1;
                            end else begin
                                state_nxt_s = PLAY;
                            end
                        end else begin
                            hold_nxt_s = hold_r - HOLD_W'(1);
                        end
                    end else begin
                        hold_nxt_s = hold_r;
                    end
                end
                MATCH_OVER: begin
                    state_nxt_s = MATCH_OVER;
                end
                default: begin
                    state_nxt_s = PLAY;
                    hold_nxt_s  = {HOLD_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.p1_score   = p1_score_r;
    assign bus.p2_score   = p2_score_r;
    assign bus.p1_rounds  = p1_rounds_r;
    assign bus.p2_rounds  = p2_rounds_r;
    assign bus.round_over = round_over_r;
    assign bus.match_over = match_over_r;
    assign bus.p1_winner  = p1_win_r;
    assign bus.p2_winner  = p2_win_r;
    assign bus.serve      = serve_r;
endmodule
